// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Package     : y86_pkg
// Description : Shared Y86-64 definitions for the writeback stage: instruction
//               codes, register ids, status encoding and the W pipeline
//               register record with its bubble value.
// Revision    : 1.0  initial release
// ============================================================================
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // "No register" id; never written, always reads as zero
    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        STAT_AOK = 2'd0,
        STAT_HLT = 2'd1,
        STAT_ADR = 2'd2,
        STAT_INS = 2'd3
    } stat_t;

    typedef struct packed {
        stat_t       stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } w_reg_t;

    // Bubble: a NOP that writes nothing and retires as AOK
    localparam w_reg_t W_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        valE:  64'd0,
        valM:  64'd0,
        dstE:  RNONE,
        dstM:  RNONE
    };

endpackage : y86_pkg
`default_nettype wire

// File: rtl/regfile_y86.sv
`default_nettype none
// ============================================================================
// Module      : regfile_y86
// Description : Y86-64 architectural register file, 2 read / 2 write ports.
//               Same-id writes resolve in favour of the M port. Id RNONE is
//               never stored and reads as zero.
//               Optional macro REG_BYPASS_EN forwards this cycle's write data
//               to the read ports (M port has priority).
// Revision    : 1.0  initial release
// ============================================================================
module regfile_y86
    import y86_pkg::*;
#(
    parameter int NREGS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        wr_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rval_a,
    output logic [63:0] rval_b
);

    logic [63:0] r_regs [0:NREGS-1];

    // Per-register write: M assignment comes last so it overrides E on a tie
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_regs[gi] <= 64'd0;
                end else begin
                    if (wr_e && (dst_e == 4'(gi))) r_regs[gi] <= val_e;
                    if (wr_m && (dst_m == 4'(gi))) r_regs[gi] <= val_m;
                end
            end
        end
    endgenerate

    function automatic logic [63:0] read_port(input logic [3:0] src);
        logic [63:0] v;
        v = 64'd0;
        if (src != RNONE) v = r_regs[src];
`ifdef REG_BYPASS_EN
        if (wr_e && (dst_e == src)) v = val_e;
        if (wr_m && (dst_m == src)) v = val_m;
`endif
        return v;
    endfunction

    // Combinational read ports for the decode stage
    always_comb begin
        rval_a = read_port(src_a);
        rval_b = read_port(src_b);
    end

endmodule : regfile_y86
`default_nettype wire

// File: rtl/writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module      : writeback_pipe
// Description : Y86-64 writeback stage: W pipeline register, register file
//               writeback, processor status, sticky halt flag and retired
//               instruction counter.
//               Optional macro REG_BYPASS_EN enables same-cycle write-to-read
//               forwarding inside the register file.
// Revision    : 1.0  initial release
// ============================================================================
module writeback_pipe
    import y86_pkg::*;
#(
    parameter int NREGS = 15,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             W_stall,
    input  logic             W_bubble,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       m_icode,
    input  logic [63:0]      m_valE,
    input  logic [63:0]      m_valM,
    input  logic [3:0]       m_dstE,
    input  logic [3:0]       m_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [3:0]       W_icode,
    output logic [63:0]      W_valE,
    output logic [63:0]      W_valM,
    output logic [3:0]       W_dstE,
    output logic [3:0]       W_dstM,
    output logic [1:0]       W_stat,
    output logic [1:0]       Stat,
    output logic             halted,
    output logic [CNT_W-1:0] instr_retired
);

    w_reg_t           r_w;
    logic             r_halted;
    logic [CNT_W-1:0] r_retired;

    w_reg_t w_m_in;
    logic   w_wr_e;
    logic   w_wr_m;
    logic   w_w_aok;

    assign w_m_in = '{
        stat:  stat_t'(m_stat),
        icode: m_icode,
        valE:  m_valE,
        valM:  m_valM,
        dstE:  m_dstE,
        dstM:  m_dstM
    };

    // Writes come from the W contents present before this edge
    assign w_w_aok = (r_w.stat == STAT_AOK);
    assign w_wr_e  = (r_w.dstE != RNONE) && w_w_aok && !r_halted && !rst;
    assign w_wr_m  = (r_w.dstM != RNONE) && w_w_aok && !r_halted && !rst;

    // W register: reset > halted hold > bubble > stall hold > load
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w <= W_BUBBLE;
        end else if (!r_halted) begin
            if (W_bubble)      r_w <= W_BUBBLE;
            else if (!W_stall) r_w <= w_m_in;
        end
    end

    // Sticky halt: set when a non-AOK status leaves W on a non-stalled cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (!r_halted && !W_stall && !w_w_aok) begin
            r_halted <= 1'b1;
        end
    end

    // Retire counter: counts real AOK instructions leaving W
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_w_aok && (r_w.icode != I_NOP) && !r_halted && !W_stall) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    regfile_y86 #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .wr_e   (w_wr_e),
        .dst_e  (r_w.dstE),
        .val_e  (r_w.valE),
        .wr_m   (w_wr_m),
        .dst_m  (r_w.dstM),
        .val_m  (r_w.valM),
        .src_a  (d_srcA),
        .src_b  (d_srcB),
        .rval_a (d_rvalA),
        .rval_b (d_rvalB)
    );

    assign W_icode       = r_w.icode;
    assign W_valE        = r_w.valE;
    assign W_valM        = r_w.valM;
    assign W_dstE        = r_w.dstE;
    assign W_dstM        = r_w.dstM;
    assign W_stat        = r_w.stat;
    assign Stat          = r_w.stat;
    assign halted        = r_halted;
    assign instr_retired = r_retired;

endmodule : writeback_pipe
`default_nettype wire

// File: tb/tb_writeback_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_pipe
// Description : Self-checking bench for writeback_pipe. Stimulus process
//               drives inputs on the falling edge and pushes the expected
//               post-edge state from a transaction-level model; a monitor
//               samples after each rising edge and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_writeback_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        W_stall = 1'b0;
    logic        W_bubble = 1'b0;
    logic [1:0]  m_stat = 2'd0;
    logic [3:0]  m_icode = 4'h1;
    logic [63:0] m_valE = 64'd0;
    logic [63:0] m_valM = 64'd0;
    logic [3:0]  m_dstE = 4'hF;
    logic [3:0]  m_dstM = 4'hF;
    logic [3:0]  d_srcA = 4'hF;
    logic [3:0]  d_srcB = 4'hF;
    logic [63:0] d_rvalA, d_rvalB;
    logic [3:0]  W_icode, W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic [1:0]  W_stat, Stat;
    logic        halted;
    logic [63:0] instr_retired;

    writeback_pipe #(.NREGS(15), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .W_stall(W_stall), .W_bubble(W_bubble),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .W_icode(W_icode), .W_valE(W_valE),
        .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_stat(W_stat),
        .Stat(Stat), .halted(halted), .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valE, valM;
        logic [3:0]  dstE, dstM;
        logic [1:0]  stat;
        logic        halted;
        logic [63:0] cnt, rva, rvb;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: architectural state only
    logic [63:0] mregs [0:15];
    logic [3:0]  mw_icode, mw_dstE, mw_dstM;
    logic [63:0] mw_valE, mw_valM;
    logic [1:0]  mw_stat;
    logic        mh;
    logic [63:0] mcnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [63:0] mread(input logic [3:0] s, input logic r);
        logic [63:0] v;
        if (s == 4'hF) return 64'd0;
        v = mregs[s];
`ifdef REG_BYPASS_EN
        if (!r && !mh && mw_stat == 2'd0) begin
            if (mw_dstE == s) v = mw_valE;
            if (mw_dstM == s) v = mw_valM;
        end
`endif
        return v;
    endfunction

    task automatic step(input logic r, input logic st, input logic bb,
                        input logic [1:0] s, input logic [3:0] ic,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] de, input logic [3:0] dm,
                        input logic [3:0] sa, input logic [3:0] sb);
        exp_t e;
        logic okw;
        @(negedge clk);
        rst = r; W_stall = st; W_bubble = bb; m_stat = s; m_icode = ic;
        m_valE = ve; m_valM = vm; m_dstE = de; m_dstM = dm; d_srcA = sa; d_srcB = sb;
        if (r) begin
            for (int i = 0; i < 16; i++) mregs[i] = 64'd0;
            mw_icode = 4'h1; mw_dstE = 4'hF; mw_dstM = 4'hF;
            mw_valE = 64'd0; mw_valM = 64'd0; mw_stat = 2'd0;
            mh = 1'b0; mcnt = 64'd0;
        end else begin
            okw = (mw_stat == 2'd0) && !mh;
            if (okw && mw_dstE != 4'hF) mregs[mw_dstE] = mw_valE;
            if (okw && mw_dstM != 4'hF) mregs[mw_dstM] = mw_valM;
            if (okw && mw_icode != 4'h1 && !st) mcnt = mcnt + 64'd1;
            if (!mh) begin
                if (mw_stat != 2'd0 && !st) mh = 1'b1;
                if (bb) begin
                    mw_icode = 4'h1; mw_dstE = 4'hF; mw_dstM = 4'hF;
                    mw_valE = 64'd0; mw_valM = 64'd0; mw_stat = 2'd0;
                end else if (!st) begin
                    mw_icode = ic; mw_dstE = de; mw_dstM = dm;
                    mw_valE = ve; mw_valM = vm; mw_stat = s;
                end
            end
        end
        e.icode = mw_icode; e.valE = mw_valE; e.valM = mw_valM;
        e.dstE = mw_dstE; e.dstM = mw_dstM; e.stat = mw_stat;
        e.halted = mh; e.cnt = mcnt; e.rva = mread(sa, r); e.rvb = mread(sb, r);
        exp_q.push_back(e);
    endtask

    task automatic nop_step(input logic [3:0] sa, input logic [3:0] sb);
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, sa, sb);
    endtask

    task automatic rand_step(input logic allow_rst);
        logic [63:0] ve, vm;
        logic r;
        ve = {$urandom, $urandom};
        vm = {$urandom, $urandom};
        r  = allow_rst && ($urandom_range(0, 39) == 0);
        step(r, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, 2'd0,
             4'($urandom_range(0, 11)), ve, vm,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    // Monitor: compare DUT state just after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("W_icode", 64'(W_icode), 64'(e.icode));
                chk("W_valE", W_valE, e.valE);
                chk("W_valM", W_valM, e.valM);
                chk("W_dstE", 64'(W_dstE), 64'(e.dstE));
                chk("W_dstM", 64'(W_dstM), 64'(e.dstM));
                chk("W_stat", 64'(W_stat), 64'(e.stat));
                chk("Stat", 64'(Stat), 64'(e.stat));
                chk("halted", 64'(halted), 64'(e.halted));
                chk("instr_retired", instr_retired, e.cnt);
                chk("d_rvalA", d_rvalA, e.rva);
                chk("d_rvalB", d_rvalB, e.rvb);
            end
        end
    end

    initial begin
        // Reset, sweeping read port A across every id
        for (int i = 0; i < 16; i++)
            step(1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 4'(i), 4'(15 - i));

        // OPQ writes 0x55 to reg 3, then read it back
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'h6, 64'h55, 64'd0, 4'd3, 4'hF, 4'd3, 4'd0);
        nop_step(4'd3, 4'd3);
        nop_step(4'd3, 4'd0);

        // Same destination on both ports: valM must win
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'hB, 64'h10, 64'h20, 4'd4, 4'd4, 4'd4, 4'd3);
        nop_step(4'd4, 4'd4);
        nop_step(4'd4, 4'd3);

        // Stall holds W and counter, then stall+bubble loads a bubble
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'h2, 64'hAA, 64'd0, 4'd5, 4'hF, 4'd5, 4'd4);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 2'd0, 4'h5, 64'(i + 100), 64'(i + 200), 4'd6, 4'd7, 4'd6, 4'd7);
        step(1'b0, 1'b1, 1'b1, 2'd0, 4'h5, 64'h1, 64'h2, 4'd6, 4'd7, 4'd5, 4'd6);
        nop_step(4'd6, 4'd7);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) rand_step(1'b1);
        step(1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 4'd0, 4'd2);
        for (int i = 0; i < 20; i++) rand_step(1'b0);

        // Address fault: no write to reg 2, halt one clock after W_stat=ADR
        step(1'b0, 1'b0, 1'b0, 2'd2, 4'h5, 64'h0, 64'hDEAD_BEEF, 4'hF, 4'd2, 4'd2, 4'd1);
        for (int i = 0; i < 6; i++) rand_step(1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF, 4'd2, 4'd1);
        step(1'b0, 1'b0, 1'b0, 2'd0, 4'h6, 64'h77, 64'd0, 4'd1, 4'hF, 4'd1, 4'd2);
        nop_step(4'd1, 4'd2);
        nop_step(4'd1, 4'd2);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_writeback_pipe
`default_nettype wire
